// File: rtl/glyph_pkg.sv
// Shared constants and helpers for the glyph ROM read path: requester count,
// ROM geometry, per-digit glyph base addresses.
package glyph_pkg;

    localparam int GLYPH_NUM_REQ     = 3;   // score, level, lines displays
    localparam int GLYPH_ADDR_W      = 14;
    localparam int GLYPH_ROM_LATENCY = 2;

    localparam int GLYPH_W    = 32;
    localparam int GLYPH_H    = 32;
    localparam int GLYPH_SIZE = GLYPH_W * GLYPH_H;
    localparam int NUM_DIGITS = 10;

    // Base address of the glyph for a decimal digit; glyphs are packed back to back.
    function automatic logic [GLYPH_ADDR_W-1:0] digit_base(input int digit);
        return GLYPH_ADDR_W'(digit * GLYPH_SIZE);
    endfunction

    // Address of one pixel inside a digit glyph, row-major.
    function automatic logic [GLYPH_ADDR_W-1:0] glyph_addr(input int digit,
                                                            input int row,
                                                            input int col);
        return GLYPH_ADDR_W'(digit * GLYPH_SIZE + row * GLYPH_W + col);
    endfunction

    // Width of a requester index; never zero even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: chooses the first set request after the last-granted
// index, wrapping from NUM_REQ-1 back to 0.
module rr_picker
    import glyph_pkg::*;
#(
    parameter int NUM_REQ = GLYPH_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    logic [IDX_W-1:0] cand;

    // Index of the i-th candidate in search order, starting one past last_idx.
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int s = base + 1 + off;
        if (s >= NUM_REQ) s -= NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Scan candidates in priority order and keep the first requesting one.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_idx(int'(last_idx), i);
            if (!win_valid && req[cand]) begin
                win_valid        = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/glyph_rom_arbiter.sv
// Shares one single-port glyph ROM between several display requesters.
// One grant per cycle, round-robin; each grant is tagged and the tag travels
// alongside the ROM latency so the returned pixel lands at the right requester.
module glyph_rom_arbiter
    import glyph_pkg::*;
#(
    parameter int NUM_REQ     = GLYPH_NUM_REQ,
    parameter int ADDR_W      = GLYPH_ADDR_W,
    parameter int ROM_LATENCY = GLYPH_ROM_LATENCY
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic [NUM_REQ-1:0]             req_in,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_in,
    output logic [NUM_REQ-1:0]             grant_out,
    output logic [ADDR_W-1:0]              rom_addr_out,
    input  logic                           rom_data_in,
    output logic [NUM_REQ-1:0]             rd_valid_out,
    output logic [NUM_REQ-1:0]             rd_data_out,
    output logic [15:0]                    contention_count_out
);

    localparam int IDX_W = idx_width(NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [NUM_REQ-1:0] masked_req;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic               contended;
    // Last-granted index; while grant_out is high it also names the current winner.
    logic [IDX_W-1:0]   last_idx_q;
    tag_t               tag_pipe [ROM_LATENCY];
    tag_t               tag_tail;

    // A requester granted this cycle is still holding req_in for the request
    // just accepted, so it sits out the next arbitration.
    assign masked_req = req_in & ~grant_out;
    assign contended  = ($countones(masked_req) > 1);
    assign tag_tail   = tag_pipe[ROM_LATENCY-1];

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (masked_req),
        .last_idx   (last_idx_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    // Register the grant, the ROM address and the round-robin pointer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: state registers use non-blocking assignments so every register
        // here sees the pre-edge values of the others, independent of order.
        if (!rst_n_in) begin
            grant_out    <= '0;
            rom_addr_out <= '0;
            last_idx_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            grant_out <= win_onehot;
            if (win_valid) begin
                last_idx_q   <= win_idx;
                rom_addr_out <= addr_in[win_idx];
            end else begin
                rom_addr_out <= '0;
            end
        end
    end

    // Tag shift register: the tail lines up with rom_data_in for that grant.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: unlike a data RAM this array is reset, because a stale valid
        // bit left over from before reset would produce a spurious response.
        if (!rst_n_in) begin
            for (int i = 0; i < ROM_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: |grant_out, idx: last_idx_q};
            for (int i = 1; i < ROM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Capture the ROM bit for the tagged requester and pulse its valid.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_valid_out <= '0;
            rd_data_out  <= '0;
        end else begin
            rd_valid_out <= '0;
            if (tag_tail.valid) begin
                rd_valid_out[tag_tail.idx] <= 1'b1;
                rd_data_out[tag_tail.idx]  <= rom_data_in;
            end
        end
    end

    // Saturating count of edges where two or more requesters compete.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            contention_count_out <= '0;
        end else if (contended && (contention_count_out != 16'hFFFF)) begin
            contention_count_out <= contention_count_out + 16'd1;
        end
    end

endmodule
